srv32_dmem_responder: RTL
=========================

// Module: srv32_dmem_responder
// PURPOSE
// - Responder (memory side) of the core's data-memory bus: services dmem_w*/dmem_r* requests from the CPU top.
// - Backing store is a word-organised SRAM array with byte strobes.
// - Programmable wait states per channel, for stall-path coverage and slow-RAM modelling.
// - Sits outside the CLINT window: the top level only forwards requests whose addr[31:28] != CLINT_BASE.
// PARAMETERS
// - DEPTH_LOG2   12  array depth = 2**DEPTH_LOG2 32-bit words; word index = addr[DEPTH_LOG2+1:2]
// - RD_WAIT       0  cycles rready must be held, with stable raddr, before rvalid is granted (0..15)
// - WR_WAIT       0  cycles wready must be held, with stable waddr, before wvalid is granted (0..15)
// PORTS
// - clk      in   1   clock
// - resetb   in   1   asynchronous active-low reset
// - wready   in   1   write request from core
// - wvalid   out  1   write accepted; write commits when wready && wvalid
// - waddr    in   32  byte address; addr[1:0] ignored
// - wdata    in   32  write data
// - wstrb    in   4   byte lane enables; bit n -> wdata[8n+7:8n]
// - rready   in   1   read request from core
// - rvalid   out  1   read accepted; handshake when rready && rvalid
// - raddr    in   32  byte address; addr[1:0] ignored
// - rresp    out  1   response status for rdata; 1 = OK
// - rdata    out  32  read data; valid the cycle after the read handshake
// BEHAVIOUR
// - Reset: resetb is asynchronous, active-low; clock is clk.
//   - In reset: wvalid=0, rvalid=0, rdata=0, rresp=1; wait counters and captured addresses cleared.
//   - Array contents are not reset.
// - Read channel, 4-bit counter rcnt:
//   - RD_WAIT=0: rvalid = rready, combinational (zero-wait).
//   - RD_WAIT>0: rvalid = rready && (rcnt == RD_WAIT).
//   - rcnt increments while rready=1 and rcnt < RD_WAIT.
//   - rcnt clears on handshake, on rready=0, or when raddr differs from the address captured in the previous cycle.
//     On such a change the wait restarts; no partial credit is kept.
// - Read data timing: on handshake, rdata/rresp are registered from the array and are visible in cycle T+1.
//   They hold until the next read handshake. Latency = RD_WAIT handshake cycles + 1 data cycle.
// - Back-to-back reads (RD_WAIT=0): one read per cycle; rdata of request N appears while request N+1 is handshaking.
// - Write channel: identical counter scheme (wcnt, WR_WAIT, waddr compare).
//   On wready && wvalid, the selected lanes are written at the clock edge. wstrb=0 is a legal no-op that still handshakes.
// - Simultaneous read and write handshake to the same word: read-before-write.
//   rdata returns the old word; the new data is visible to the next read.
// - Channels are independent. Neither channel blocks the other.
// - Reset asserted mid-wait: counters drop to 0 and the pending request restarts after reset.
//   A write not yet handshaked is never committed.
// - rvalid/wvalid are never asserted without the matching ready (no unsolicited responses).
// CONFIGURATION
// - Macro DMEM_BUSERR_EN.
// - Defined:
//   - An access is out-of-range if addr[31:DEPTH_LOG2+2] != 0.
//   - Out-of-range read: handshakes normally; rresp=0 and rdata=32'h0 in the data cycle.
//   - Out-of-range write: handshakes and is discarded; array unchanged.
// - Undefined: upper address bits are ignored (aliasing modulo array size); rresp is tied to 1.
// TESTING
// - Reset, then idle -> wvalid=0, rvalid=0, rresp=1, rdata=0.
// - RD_WAIT=0, WR_WAIT=0: write 0x1000=0xDEADBEEF with wstrb=4'hF, then read 0x1000
//   -> 1-cycle handshakes; rdata=0xDEADBEEF one cycle after the read handshake.
// - Byte strobes: word 0x11223344, then write 0xAABBCCDD with wstrb=4'b0101 -> read returns 0x11BB33DD.
// - RD_WAIT=3: rready held at 0x20 -> rvalid rises in the 4th cycle.
//   Change raddr in cycle 2 -> counter restarts; rvalid 3 cycles after the change.
// - Same-cycle read and write to 0x40 (old 0x1, new 0x2) -> rdata=0x1; the following read returns 0x2.
// - DMEM_BUSERR_EN, DEPTH_LOG2=12: read 0x0001_0000 -> rresp=0, rdata=0.
//   Write to the same address, then read 0x0 -> word 0 unchanged.
//   Without the macro, the same read aliases to word 0 with rresp=1.
// - Assert resetb=0 mid-wait with WR_WAIT=5 -> no array write occurs; wvalid=0 until 5 cycles after the request reasserts.

Source files
------------

// File: rtl/srv32_dmem_responder.sv
// Memory-side responder for the srv32 data bus: byte-strobed word SRAM with per-channel wait states.
// Optional `DMEM_BUSERR_EN flags out-of-range accesses (rresp=0, writes dropped); default build aliases.
module srv32_dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned RD_WAIT    = 0,
  parameter int unsigned WR_WAIT    = 0
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        wready,
  output logic        wvalid,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        rready,
  output logic        rvalid,
  input  logic [31:0] raddr,
  output logic        rresp,
  output logic [31:0] rdata
);

  localparam int unsigned Words  = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  RdWait = 4'(RD_WAIT);
  localparam logic [3:0]  WrWait = 4'(WR_WAIT);

  logic [31:0] mem [Words];

  logic [DEPTH_LOG2-1:0] ridx;
  logic [DEPTH_LOG2-1:0] widx;
  logic                  r_ok;
  logic                  w_ok;

  assign ridx = raddr[DEPTH_LOG2+1:2];
  assign widx = waddr[DEPTH_LOG2+1:2];

`ifdef DMEM_BUSERR_EN
  assign r_ok = (raddr[31:DEPTH_LOG2+2] == '0);
  assign w_ok = (waddr[31:DEPTH_LOG2+2] == '0);
`else
  assign r_ok = 1'b1;
  assign w_ok = 1'b1;
`endif

  logic [3:0]  rcnt_q, rcnt_d, rcnt_cur;
  logic [3:0]  wcnt_q, wcnt_d, wcnt_cur;
  logic [31:0] raddr_q, waddr_q;
  logic [31:0] rdata_q;
  logic        rresp_q;

  // An address change since last cycle voids accumulated wait; the current cycle starts the new wait.
  always_comb begin
    rcnt_cur = (raddr == raddr_q) ? rcnt_q : 4'd0;
    rvalid   = rready && (rcnt_cur == RdWait);
    rcnt_d   = 4'd0;
    if (rready && !rvalid) begin
      rcnt_d = rcnt_cur + 4'd1;
    end
  end

  always_comb begin
    wcnt_cur = (waddr == waddr_q) ? wcnt_q : 4'd0;
    wvalid   = wready && (wcnt_cur == WrWait);
    wcnt_d   = 4'd0;
    if (wready && !wvalid) begin
      wcnt_d = wcnt_cur + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rcnt_q  <= 4'd0;
      wcnt_q  <= 4'd0;
      raddr_q <= 32'd0;
      waddr_q <= 32'd0;
      rdata_q <= 32'd0;
      rresp_q <= 1'b1;
    end else begin
      rcnt_q  <= rcnt_d;
      wcnt_q  <= wcnt_d;
      raddr_q <= raddr;
      waddr_q <= waddr;
      if (rvalid) begin
        rdata_q <= r_ok ? mem[ridx] : 32'd0;
        rresp_q <= r_ok;
      end
    end
  end

  // Array is not reset; the read port above samples the pre-write value on a same-word collision.
  always_ff @(posedge clk) begin
    if (wvalid && w_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;
  assign rresp = rresp_q;

endmodule
